// File: rtl/mix_decim_if.sv
// Sample bus between the mixer output and the integrate-and-dump decimator.
// master drives samples and control; slave is the decimator.
interface mix_decim_if #(
  parameter int DW = 20
);
  logic signed [DW-1:0] din;
  logic                 din_vld;
  logic [1:0]           dec_sel;
  logic                 clr;
  logic signed [DW-1:0] dout;
  logic                 dout_vld;
  logic                 busy;

  modport master (
    output din, din_vld, dec_sel, clr,
    input  dout, dout_vld, busy
  );

  modport slave (
    input  din, din_vld, dec_sel, clr,
    output dout, dout_vld, busy
  );
endinterface

// File: rtl/mix_decim.sv
// Integrate-and-dump decimator: averages N = 8/16/32/64 valid samples and
// emits one rounded (half-up) signed average per frame.
module mix_decim #(
  parameter int DW = 20,
  parameter int AW = 26
) (
  input  logic       clk,
  input  logic       rst,
  mix_decim_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  logic [0:0]           r_state;
  logic signed [AW-1:0] r_acc;
  logic [5:0]           r_cnt;
  logic [1:0]           r_dsel;
  logic signed [DW-1:0] r_dout;
  logic                 r_vld;

  logic [2:0]           w_k;
  logic [5:0]           w_last;
  logic signed [AW-1:0] w_din;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_half;
  logic signed [AW-1:0] w_rnd;
  logic signed [DW-1:0] w_avg;

  // k = log2(N); the frame length is fixed by the dec_sel latched at frame start
  assign w_k    = 3'd3 + {1'b0, r_dsel};
  assign w_last = 6'((7'd1 << w_k) - 7'd1);
  assign w_din  = {{(AW-DW){bus.din[DW-1]}}, bus.din};
  assign w_sum  = r_acc + w_din;
  assign w_half = {{(AW-1){1'b0}}, 1'b1} << (w_k - 3'd1);
  assign w_rnd  = w_sum + w_half;
  // |sum| <= 2^25, so the shifted result always fits DW bits
  assign w_avg  = DW'(w_rnd >>> w_k);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dsel  <= '0;
      r_dout  <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (bus.clr) begin
        r_state <= S_IDLE;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (bus.din_vld) begin
        case (r_state)
          S_IDLE: begin
            r_dsel  <= bus.dec_sel;
            r_acc   <= w_din;
            r_cnt   <= 6'd1;
            r_state <= S_ACC;
          end
          default: begin
            if (r_cnt == w_last) begin
              r_dout  <= w_avg;
              r_vld   <= 1'b1;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + 6'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.dout     = r_dout;
  assign bus.dout_vld = r_vld;
  assign bus.busy     = (r_state == S_ACC);

endmodule
